// File: rtl/qspi_psram_target.sv
// qspi_psram_target: PSRAM-side responder for the CPU quad-SPI master.
// Serves 0xEB (fast read quad), 0x38 (quad write) and the 0x66/0x99 reset
// pair against an internal byte-wide memory, with a backdoor read port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ce_n high or waiting for ce_n to fall
// CMD   | shifting in the 8-bit command on sio[0]
// ADR   | shifting in six address nibbles on sio[3:0]
// WDAT  | quad write, nibble pairs written to memory
// DUMMY | counting dummy falls before read data
// RDAT  | driving read nibbles on each sck fall
// SKIP  | command done or unknown, ignore sck until ce_n rises
module qspi_psram_target #(
   parameter int ADDR_BITS    = 12,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sck,
   input  logic                 ce_n,
   input  logic [3:0]           sio_i,
   output logic [3:0]           sio_o,
   output logic                 sio_oe,
   output logic                 rst_pulse,
   output logic [7:0]           last_cmd,
   input  logic [ADDR_BITS-1:0] bd_adr,
   output logic [7:0]           bd_rdata
);

   localparam int DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, CMD, ADR, WDAT, DUMMY, RDAT, SKIP
   } state_t;

   state_t state, state_nx;

   logic sck_m, sck_s, sck_d;
   logic ce_m, ce_s, ce_d;
   logic [3:0] sio_m, sio_s;
   logic rise, fall;

   logic [7:0]           shreg;
   logic [2:0]           bit_cnt;
   logic [ADDR_BITS-1:0] adr;
   logic [DW-1:0]        dcnt;
   logic                 half;
   logic [3:0]           wr_hi;
   logic [3:0]           rd_lo;
   logic                 rst_en;

   logic [7:0] mem [2**ADDR_BITS];
   logic [7:0] cmd_byte;
   logic [7:0] rd_byte;
   logic       mem_we;

   assign rise     = sck_s & ~sck_d;
   assign fall     = ~sck_s & sck_d;
   assign cmd_byte = {shreg[6:0], sio_s[0]};
   assign rd_byte  = mem[adr];
   assign mem_we   = (state == WDAT) && !ce_s && rise && half;

   // Two-flop synchronisers plus one delay stage for edge detection; sck and
   // ce_n reset to their idle-high level so no false edge appears on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_m <= 1'b1;
         sck_s <= 1'b1;
         sck_d <= 1'b1;
         ce_m  <= 1'b1;
         ce_s  <= 1'b1;
         ce_d  <= 1'b1;
         sio_m <= 4'h0;
         sio_s <= 4'h0;
      end else begin
         sck_m <= sck;
         sck_s <= sck_m;
         sck_d <= sck_s;
         ce_m  <= ce_n;
         ce_s  <= ce_m;
         ce_d  <= ce_s;
         sio_m <= sio_i;
         sio_s <= sio_m;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; a deselect always wins and returns to IDLE.
   always_comb begin
      state_nx = state;
      if (ce_s) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:  if (ce_d) state_nx = CMD;
            CMD:   if (rise && bit_cnt == 3'd7) begin
                      if (cmd_byte == 8'hEB || cmd_byte == 8'h38) state_nx = ADR;
                      else                                        state_nx = SKIP;
                   end
            ADR:   if (rise && bit_cnt == 3'd5)
                      state_nx = (last_cmd == 8'h38) ? WDAT : DUMMY;
            DUMMY: if (fall && dcnt == '0) state_nx = RDAT;
            default: state_nx = state;
         endcase
      end
   end

   // Protocol datapath: shifting, address counting, read-data drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= 8'h00;
         bit_cnt   <= 3'd0;
         adr       <= '0;
         dcnt      <= '0;
         half      <= 1'b0;
         wr_hi     <= 4'h0;
         rd_lo     <= 4'h0;
         rst_en    <= 1'b0;
         rst_pulse <= 1'b0;
         last_cmd  <= 8'h00;
         sio_o     <= 4'h0;
         sio_oe    <= 1'b0;
      end else begin
         rst_pulse <= 1'b0;
         if (state != RDAT) sio_oe <= 1'b0;
         if (ce_s) begin
            bit_cnt <= 3'd0;
            half    <= 1'b0;
            sio_oe  <= 1'b0;
         end else begin
            case (state)
               CMD: if (rise) begin
                  shreg   <= cmd_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     last_cmd <= cmd_byte;
                     if (cmd_byte == 8'h66) begin
                        rst_en <= 1'b1;
                     end else begin
                        rst_en <= 1'b0;
                        if (cmd_byte == 8'h99 && rst_en) rst_pulse <= 1'b1;
                     end
                  end
               end
               ADR: if (rise) begin
                  // Only the low ADDR_BITS of the 24-bit address survive the shift.
                  adr     <= {adr[ADDR_BITS-5:0], sio_s};
                  bit_cnt <= (bit_cnt == 3'd5) ? 3'd0 : bit_cnt + 3'd1;
                  dcnt    <= DW'(DUMMY_CYCLES - 1);
               end
               WDAT: if (rise) begin
                  if (!half) begin
                     wr_hi <= sio_s;
                     half  <= 1'b1;
                  end else begin
                     half <= 1'b0;
                     adr  <= adr + ADDR_BITS'(1);
                  end
               end
               DUMMY: if (fall) begin
                  if (dcnt == '0) begin
                     sio_o  <= rd_byte[7:4];
                     rd_lo  <= rd_byte[3:0];
                     adr    <= adr + ADDR_BITS'(1);
                     half   <= 1'b1;
                     sio_oe <= 1'b1;
                  end else begin
                     dcnt <= dcnt - DW'(1);
                  end
               end
               RDAT: if (fall) begin
                  if (half) begin
                     sio_o <= rd_lo;
                     half  <= 1'b0;
                  end else begin
                     sio_o <= rd_byte[7:4];
                     rd_lo <= rd_byte[3:0];
                     adr   <= adr + ADDR_BITS'(1);
                     half  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Memory write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[adr] <= {wr_hi, sio_s};
   end

   // Backdoor read, registered; a same-cycle protocol write returns old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bd_rdata <= 8'h00;
      else     bd_rdata <= mem[bd_adr];
   end

endmodule

// File: tb/tb_qspi_psram_target.sv
// tb_qspi_psram_target: directed bench for the QSPI PSRAM responder.
module tb_qspi_psram_target;

   localparam int AB   = 12;
   localparam int DC   = 8;
   localparam int HALF = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          sck;
   logic          ce_n;
   logic [3:0]    sio_i;
   logic [3:0]    sio_o;
   logic          sio_oe;
   logic          rst_pulse;
   logic [7:0]    last_cmd;
   logic [AB-1:0] bd_adr;
   logic [7:0]    bd_rdata;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int oe_cnt   = 0;
   int pulse_cnt = 0;

   typedef struct {
      int            phase;
      logic [AB-1:0] adr;
      logic [7:0]    exp;
   } bd_vec_t;

   bd_vec_t bd_tab [19];

   qspi_psram_target #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
      .sio_o(sio_o), .sio_oe(sio_oe), .rst_pulse(rst_pulse),
      .last_cmd(last_cmd), .bd_adr(bd_adr), .bd_rdata(bd_rdata)
   );

   always #5 clk = ~clk;

   // Cycle counters for output-enable and reset-pulse activity.
   always @(posedge clk) begin
      if (sio_oe)    oe_cnt    <= oe_cnt + 1;
      if (rst_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic sck_out(input logic [3:0] nib);
      sck = 1'b0; sio_i = nib; #HALF;
      sck = 1'b1; #HALF;
   endtask

   task automatic sck_in(output logic [3:0] nib, output logic oe);
      sck = 1'b0; #(HALF - 10);
      nib = sio_o; oe = sio_oe; #10;
      sck = 1'b1; #HALF;
   endtask

   task automatic xfer_start();
      ce_n = 1'b0; #HALF;
   endtask

   task automatic xfer_end();
      ce_n = 1'b1; sio_i = 4'h0; #(3 * HALF);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sck_out({3'b000, b[i]});
   endtask

   task automatic send_adr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) sck_out(a[i*4 +: 4]);
   endtask

   task automatic wr_byte(input logic [7:0] b);
      sck_out(b[7:4]);
      sck_out(b[3:0]);
   endtask

   task automatic cmd_only(input logic [7:0] b);
      xfer_start(); send_cmd(b); xfer_end();
   endtask

   task automatic bd_check(input logic [AB-1:0] a, input logic [7:0] exp);
      bd_adr = a; #20;
      check($sformatf("bd_mem[%03h]", a), 32'(bd_rdata), 32'(exp));
   endtask

   task automatic check_phase(input int p);
      for (int i = 0; i < 19; i++)
         if (bd_tab[i].phase == p) bd_check(bd_tab[i].adr, bd_tab[i].exp);
   endtask

   // Dummy phase then n nibbles compared with the expected list.
   task automatic read_nibbles(input string name, input logic [23:0] a,
                               input logic [31:0] exp_nibs, input int n);
      logic [3:0] nib;
      logic       oe;
      logic       pre_oe;
      xfer_start();
      send_cmd(8'hEB);
      send_adr(a);
      pre_oe = 1'b0;
      for (int d = 0; d < DC - 1; d++) begin
         sck_in(nib, oe);
         pre_oe |= oe;
      end
      check({name, "_oe_dummy"}, 32'(pre_oe), 32'd0);
      for (int i = 0; i < n; i++) begin
         sck_in(nib, oe);
         check($sformatf("%s_nib%0d", name, i), 32'(nib), 32'(exp_nibs[(7-i)*4 +: 4]));
         check($sformatf("%s_oe%0d", name, i), 32'(oe), 32'd1);
      end
      ce_n = 1'b1; #60;
      check({name, "_oe_after_ce"}, 32'(sio_oe), 32'd0);
      xfer_end();
   endtask

   initial begin
      int oe0;
      int p0;
      logic [3:0] nib;
      logic       oe;

      bd_tab = '{
         '{1, 12'h010, 8'h78}, '{1, 12'h011, 8'h56}, '{1, 12'h012, 8'h34}, '{1, 12'h013, 8'h12},
         '{2, 12'h020, 8'hAB}, '{2, 12'h021, 8'hEE},
         '{3, 12'hFFE, 8'h11}, '{3, 12'hFFF, 8'h22}, '{3, 12'h000, 8'h33}, '{3, 12'h001, 8'h44},
         '{4, 12'h010, 8'h78}, '{4, 12'h013, 8'h12}, '{4, 12'h020, 8'hAB}, '{4, 12'h021, 8'hEE},
         '{4, 12'h000, 8'h33}, '{4, 12'hFFF, 8'h22},
         '{5, 12'h040, 8'h5A}, '{5, 12'h041, 8'hC3}, '{5, 12'h010, 8'h78}
      };

      rst = 1'b1; sck = 1'b1; ce_n = 1'b1; sio_i = 4'h0; bd_adr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sio_o",     32'(sio_o),     32'd0);
      check("rst_sio_oe",    32'(sio_oe),    32'd0);
      check("rst_rst_pulse", 32'(rst_pulse), 32'd0);
      check("rst_last_cmd",  32'(last_cmd),  32'd0);
      check("rst_bd_rdata",  32'(bd_rdata),  32'd0);
      rst = 1'b0; #(2 * HALF);

      // Write word 0x12345678 little-endian at 0x10.
      oe0 = oe_cnt;
      xfer_start(); send_cmd(8'h38); send_adr(24'h000010);
      wr_byte(8'h78); wr_byte(8'h56); wr_byte(8'h34); wr_byte(8'h12);
      xfer_end();
      check("wr_oe_never", 32'(oe_cnt - oe0), 32'd0);
      check("wr_last_cmd", 32'(last_cmd), 32'h38);
      check_phase(1);

      read_nibbles("rd10", 24'h000010, 32'h78563412, 8);
      check("rd_last_cmd", 32'(last_cmd), 32'hEB);

      // Prefill then abort after three nibbles.
      xfer_start(); send_cmd(8'h38); send_adr(24'h000020);
      wr_byte(8'hEE); wr_byte(8'hEE); xfer_end();
      xfer_start(); send_cmd(8'h38); send_adr(24'h000020);
      sck_out(4'hA); sck_out(4'hB); sck_out(4'hC);
      xfer_end();
      check_phase(2);

      // Address wrap across the top of memory; upper address bits ignored.
      xfer_start(); send_cmd(8'h38); send_adr(24'hABCFFE);
      wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
      xfer_end();
      check_phase(3);

      // Reset enable then reset.
      p0 = pulse_cnt;
      cmd_only(8'h66);
      check("rst_en_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      cmd_only(8'h99);
      check("rst_seq_pulse", 32'(pulse_cnt - p0), 32'd1);
      check("rst_seq_last_cmd", 32'(last_cmd), 32'h99);
      p0 = pulse_cnt;
      cmd_only(8'h99);
      check("rst_alone_pulse", 32'(pulse_cnt - p0), 32'd0);
      check("rst_alone_last_cmd", 32'(last_cmd), 32'h99);
      p0 = pulse_cnt;
      cmd_only(8'h66); cmd_only(8'h03); cmd_only(8'h99);
      check("rst_broken_pulse", 32'(pulse_cnt - p0), 32'd0);

      // Unknown command followed by toggling sck/sio.
      oe0 = oe_cnt;
      xfer_start(); send_cmd(8'h03);
      for (int i = 0; i < 20; i++) sck_out((i % 2 == 0) ? 4'hF : 4'h5);
      xfer_end();
      check("unk_last_cmd", 32'(last_cmd), 32'h03);
      check("unk_oe_never", 32'(oe_cnt - oe0), 32'd0);
      check_phase(4);

      read_nibbles("rdwrap", 24'h000FFF, 32'h22330000, 4);

      // Reset in the middle of a read.
      xfer_start(); send_cmd(8'hEB); send_adr(24'h000010);
      for (int d = 0; d < DC + 1; d++) sck_in(nib, oe);
      check("midrd_oe_before_rst", 32'(oe), 32'd1);
      check("midrd_nib_before_rst", 32'(nib), 32'h8);
      sck = 1'b0; #50;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrd_oe_after_rst", 32'(sio_oe), 32'd0);
      check("midrd_sio_o_after_rst", 32'(sio_o), 32'd0);
      ce_n = 1'b1; sck = 1'b1; #(2 * HALF);
      rst = 1'b0; #(2 * HALF);

      // Reset mid-write: the half byte must not land; reset also clears the enable flag.
      xfer_start(); send_cmd(8'h38); send_adr(24'h000040);
      wr_byte(8'h5A); wr_byte(8'hC3); sck_out(4'h9);
      rst = 1'b1; #20;
      ce_n = 1'b1; #(2 * HALF);
      rst = 1'b0; #(2 * HALF);
      check_phase(5);
      p0 = pulse_cnt;
      cmd_only(8'h66);
      rst = 1'b1; #20; rst = 1'b0; #(2 * HALF);
      cmd_only(8'h99);
      check("rst_clears_flag", 32'(pulse_cnt - p0), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/qspi_psram_target.md
Name: qspi_psram_target

Overview:
- Synthesizable QSPI responder: the PSRAM-side end of the quad-SPI link driven by the CPU's QSPI master.
- Used in the qspi_innermem build and in the FPGA bench in place of an external PSRAM part.
- Decodes 0xEB (fast read quad), 0x38 (quad write) and 0x66/0x99 (reset enable/reset) against an internal byte-wide memory.
- Provides a backdoor read port for checking.

Parameters:
ADDR_BITS, 12, byte address width of the internal memory (2^ADDR_BITS bytes); upper bits of the 24-bit address are ignored.
DUMMY_CYCLES, 8, SCK falling edges between the last address rising edge and the first read-data nibble drive.

Ports:
clk  input  1  system clock; must be at least 8x the SCK frequency.
rst  input  1  asynchronous active-high reset.
sck  input  1  QSPI clock from master; idles high.
ce_n  input  1  chip enable, active low.
sio_i  input  4  sio lines from master.
sio_o  output  4  read-data nibble.
sio_oe  output  1  output enable for sio_o.
rst_pulse  output  1  one-clk pulse when a valid 0x66 then 0x99 sequence completes.
last_cmd  output  8  last fully received command byte.
bd_adr  input  ADDR_BITS  backdoor byte address.
bd_rdata  output  8  memory byte at bd_adr, registered, 1-clk latency.

Behaviour:
- Reset values:
  - sio_o=0, sio_oe=0, rst_pulse=0, last_cmd=0, bd_rdata=0.
  - FSM=IDLE, reset-enable flag=0.
  - Memory contents are not reset.
- Input synchronisation and edge detection:
  - sck, ce_n and sio_i pass through 2-FF synchronisers.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
  - All protocol actions use the synced signals.
- Sampling and driving:
  - Data is sampled on rise.
  - Read data changes on fall; sio_o/sio_oe are registered and update 1 clk after the fall is detected.
- States: IDLE, CMD, ADR, WDAT, DUMMY, RDAT, SKIP.
- ce_n_s high in any state: next clk goes to IDLE; sio_oe=0; partial byte discarded; bit counters cleared.
- IDLE:
  - ce_n_s falling enters CMD with bit count 0.
- CMD:
  - Shift sio_s[0] MSB-first on each rise.
  - On the 8th rise, load last_cmd and decode the command:
    - 0xEB or 0x38: go to ADR.
    - 0x66: set the reset-enable flag; go to SKIP.
    - 0x99 with flag set: pulse rst_pulse; clear flag; go to SKIP.
    - Anything else, including 0x99 with flag clear: clear flag; go to SKIP.
- ADR:
  - 6 nibbles on sio_s[3:0], MSB nibble first, one per rise; form a 24-bit address.
  - After the 6th rise: 0x38 goes to WDAT; 0xEB goes to DUMMY.
- WDAT:
  - Nibble pairs, high nibble first, form one byte.
  - On the 2nd rise of the pair, write mem[adr] and increment adr.
  - Adr wraps 2^ADDR_BITS-1 -> 0.
  - Unbounded length until ce_n rises; an incomplete byte at ce_n rise is not written.
- DUMMY:
  - The byte at adr is prefetched into a shift register.
  - Count falls; on the DUMMY_CYCLES-th fall, drive the high nibble, set sio_oe=1 and go to RDAT.
- RDAT:
  - Each fall drives the next nibble: low nibble of the current byte, then the high nibble of mem[adr+1] (prefetched), and so on.
  - Adr increments and wraps as in WDAT.
  - sio_oe stays 1 until ce_n rises.
- SKIP:
  - Ignore all sck activity; sio_oe=0 until ce_n rises.
- Memory:
  - Single write port (protocol side) and two read ports (protocol prefetch, backdoor).
  - A protocol write and a backdoor read of the same byte in the same clk returns the old data.
- rst asserted mid-transaction: immediate return to the reset state; an in-flight byte is not written.

Test Plan:
- Write word: ce_n low, cmd 0x38, adr 0x000010, data nibbles 7,8,5,6,3,4,1,2, ce_n high -> backdoor bytes 0x10..0x13 = 78,56,34,12; sio_oe never 1.
- Read back: cmd 0xEB, adr 0x000010, 8 dummy falls -> nibbles 7,8,5,6,3,4,1,2 driven one per fall, each stable at the next rise; sio_oe=1 from the DUMMY_CYCLES-th fall to ce_n high.
- Abort: cmd 0x38, adr 0x000020, 3 data nibbles A,B,C, ce_n high -> mem[0x20]=0xAB, mem[0x21] unchanged; FSM=IDLE within 3 clk.
- Wrap: write 4 bytes 11,22,33,44 at 0x000FFE (ADDR_BITS=12) -> mem[0xFFE]=11, mem[0xFFF]=22, mem[0x000]=33, mem[0x001]=44.
- Reset sequence: 0x66 transaction then 0x99 transaction -> rst_pulse high exactly 1 clk; 0x99 alone -> no pulse; last_cmd=0x99 in both cases.
- Unknown cmd 0x03 followed by 20 SCK cycles with sio toggling -> last_cmd=0x03, sio_oe=0, memory unchanged; rst asserted mid-read -> sio_oe=0 at the next clk edge.
